// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with per-entry saturating direction counters.
// Combinational lookup for IF, single-cycle training from resolved branches, plus update/mispredict statistics.
module branch_target_predictor #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [XLEN-1:0]      lookup_pc,
  output logic                 pred_hit,
  output logic                 pred_taken,
  output logic [XLEN-1:0]      pred_target,
  input  logic                 flush,
  input  logic                 upd_valid,
  input  logic [XLEN-1:0]      upd_pc,
  input  logic                 upd_taken,
  input  logic                 upd_is_jump,
  input  logic [XLEN-1:0]      upd_target,
  input  logic                 upd_mispredict,
  output logic [CNT_WIDTH-1:0] branch_cnt,
  output logic [CNT_WIDTH-1:0] mispred_cnt
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W   = XLEN - INDEX_BITS - 2;

  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1);

  logic [ENTRIES-1:0]  valid_q;
  logic [ENTRIES-1:0]  is_jump_q;
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [XLEN-1:0]     target_q [ENTRIES];

  logic [INDEX_BITS-1:0] lk_idx;
  logic [TAG_W-1:0]      lk_tag;
  logic [INDEX_BITS-1:0] u_idx;
  logic [TAG_W-1:0]      u_tag;
  logic                  u_hit;

  logic                  wr_en;
  logic                  wr_alloc;
  logic                  wr_target;
  logic [CTR_BITS-1:0]   nxt_ctr;
  logic                  nxt_jump;

  // Instructions are word aligned; the low PC bits never select or tag an entry.
  logic unused_pc_bits;

  always_comb begin
    lk_idx         = lookup_pc[INDEX_BITS+1:2];
    lk_tag         = lookup_pc[XLEN-1:INDEX_BITS+2];
    u_idx          = upd_pc[INDEX_BITS+1:2];
    u_tag          = upd_pc[XLEN-1:INDEX_BITS+2];
    unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};
  end

  // Lookup reads the registered table, so a same-cycle update is seen only from the next cycle.
  always_comb begin
    pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken  = pred_hit && (is_jump_q[lk_idx] || ctr_q[lk_idx][CTR_BITS-1]);
    pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + XLEN'(4);
  end

  always_comb begin
    u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    wr_en     = 1'b0;
    wr_alloc  = 1'b0;
    wr_target = 1'b0;
    nxt_ctr   = ctr_q[u_idx];
    nxt_jump  = is_jump_q[u_idx];
    if (upd_valid && !flush) begin
      if (u_hit) begin
        wr_en = 1'b1;
        if (upd_is_jump) begin
          nxt_ctr   = CTR_MAX;
          nxt_jump  = 1'b1;
          wr_target = 1'b1;
        end else if (upd_taken) begin
          if (nxt_ctr != CTR_MAX) nxt_ctr = nxt_ctr + CTR_BITS'(1);
          wr_target = 1'b1;
        end else begin
          if (nxt_ctr != '0) nxt_ctr = nxt_ctr - CTR_BITS'(1);
        end
      end else if (upd_taken) begin
        wr_en     = 1'b1;
        wr_alloc  = 1'b1;
        wr_target = 1'b1;
        nxt_jump  = upd_is_jump;
        nxt_ctr   = upd_is_jump ? CTR_MAX : CTR_WT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= '0;
      is_jump_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ctr_q[INDEX_BITS'(i)] <= CTR_WNT;
      end
    end else if (flush) begin
      valid_q <= '0;
    end else if (wr_en) begin
      if (wr_alloc) valid_q[u_idx] <= 1'b1;
      ctr_q[u_idx]     <= nxt_ctr;
      is_jump_q[u_idx] <= nxt_jump;
    end
  end

  // Tag and target are only meaningful behind valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_alloc)  tag_q[u_idx]    <= u_tag;
      if (wr_target) target_q[u_idx] <= upd_target;
    end
  end

  // Statistics count every accepted update, including one that a flush blocks from the table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (upd_valid) begin
      branch_cnt <= branch_cnt + CNT_WIDTH'(1);
      if (upd_mispredict) mispred_cnt <= mispred_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: training, aliasing, jumps, flush, async reset and wrap-around.
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        flush;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_is_jump;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [3:0]  branch_cnt;
  logic [3:0]  mispred_cnt;

  int n_vec = 0;
  int n_err = 0;

  branch_target_predictor #(
    .XLEN(32),
    .INDEX_BITS(6),
    .CTR_BITS(2),
    .CNT_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .lookup_pc(lookup_pc),
    .pred_hit(pred_hit),
    .pred_taken(pred_taken),
    .pred_target(pred_target),
    .flush(flush),
    .upd_valid(upd_valid),
    .upd_pc(upd_pc),
    .upd_taken(upd_taken),
    .upd_is_jump(upd_is_jump),
    .upd_target(upd_target),
    .upd_mispredict(upd_mispredict),
    .branch_cnt(branch_cnt),
    .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic tk,
                         input logic jmp, input logic [31:0] tgt, input logic mp);
    upd_valid      = v;
    upd_pc         = pc;
    upd_taken      = tk;
    upd_is_jump    = jmp;
    upd_target     = tgt;
    upd_mispredict = mp;
  endtask

  task automatic idle();
    set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    lookup_pc = 32'h100;
    #2;
    n_vec++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL reset_hit got=%0h want=0", pred_hit); end
    n_vec++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_taken got=%0h want=0", pred_taken); end
    n_vec++; if (pred_target !== 32'h104) begin n_err++; $display("FAIL reset_target got=%08h want=00000104", pred_target); end
    n_vec++; if (branch_cnt !== 4'd0) begin n_err++; $display("FAIL reset_branch_cnt got=%0d want=0", branch_cnt); end
    n_vec++; if (mispred_cnt !== 4'd0) begin n_err++; $display("FAIL reset_mispred_cnt got=%0d want=0", mispred_cnt); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_train();
    set_upd(1'b1, 32'h100, 1'b1, 1'b0, 32'h40, 1'b0);
    tick(); idle(); lookup_pc = 32'h100; #1;
    n_vec++; if (pred_hit !== 1'b1) begin n_err++; $display("FAIL train_alloc_hit got=%0h want=1", pred_hit); end
    n_vec++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL train_alloc_taken got=%0h want=1", pred_taken); end
    n_vec++; if (pred_target !== 32'h40) begin n_err++; $display("FAIL train_alloc_target got=%08h want=00000040", pred_target); end
    // ctr 2 -> 1
    set_upd(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(); idle(); #1;
    n_vec++; if (pred_hit !== 1'b1) begin n_err++; $display("FAIL train_nt1_hit got=%0h want=1", pred_hit); end
    n_vec++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL train_nt1_taken got=%0h want=0", pred_taken); end
    n_vec++; if (pred_target !== 32'h104) begin n_err++; $display("FAIL train_nt1_target got=%08h want=00000104", pred_target); end
    // ctr 1 -> 0 -> stays 0
    set_upd(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
    tick(); tick(); idle(); #1;
    n_vec++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL train_nt3_taken got=%0h want=0", pred_taken); end
    // ctr 0 -> 1 : still not taken, proving no underflow wrap
    set_upd(1'b1, 32'h100, 1'b1, 1'b0, 32'h44, 1'b0);
    tick(); idle(); #1;
    n_vec++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL train_sat0_taken got=%0h want=0", pred_taken); end
    n_vec++; if (pred_target !== 32'h104) begin n_err++; $display("FAIL train_sat0_target got=%08h want=00000104", pred_target); end
    // ctr 1 -> 2 : taken to the retrained target
    set_upd(1'b1, 32'h100, 1'b1, 1'b0, 32'h44, 1'b0);
    tick(); idle(); #1;
    n_vec++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL train_retake_taken got=%0h want=1", pred_taken); end
    n_vec++; if (pred_target !== 32'h44) begin n_err++; $display("FAIL train_retake_target got=%08h want=00000044", pred_target); end
    n_vec++; if (branch_cnt !== 4'd6) begin n_err++; $display("FAIL train_branch_cnt got=%0d want=6", branch_cnt); end
  endtask

  task automatic test_alias();
    set_upd(1'b1, 32'h200, 1'b1, 1'b0, 32'h80, 1'b0);
    tick(); idle(); lookup_pc = 32'h100; #1;
    n_vec++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL alias_old_hit got=%0h want=0", pred_hit); end
    n_vec++; if (pred_target !== 32'h104) begin n_err++; $display("FAIL alias_old_target got=%08h want=00000104", pred_target); end
    lookup_pc = 32'h200; #1;
    n_vec++; if (pred_hit !== 1'b1) begin n_err++; $display("FAIL alias_new_hit got=%0h want=1", pred_hit); end
    n_vec++; if (pred_target !== 32'h80) begin n_err++; $display("FAIL alias_new_target got=%08h want=00000080", pred_target); end
    n_vec++; if (branch_cnt !== 4'd7) begin n_err++; $display("FAIL alias_branch_cnt got=%0d want=7", branch_cnt); end
  endtask

  task automatic test_jump();
    set_upd(1'b1, 32'h300, 1'b1, 1'b1, 32'h10, 1'b1);
    lookup_pc = 32'h300; #1;
    n_vec++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL jump_rdw_hit got=%0h want=0", pred_hit); end
    tick(); idle(); #1;
    n_vec++; if (pred_hit !== 1'b1) begin n_err++; $display("FAIL jump_alloc_hit got=%0h want=1", pred_hit); end
    n_vec++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL jump_alloc_taken got=%0h want=1", pred_taken); end
    n_vec++; if (pred_target !== 32'h10) begin n_err++; $display("FAIL jump_alloc_target got=%08h want=00000010", pred_target); end
    // ctr 3 -> 2 -> 1 ; is_jump stays set and target is not rewritten
    set_upd(1'b1, 32'h300, 1'b0, 1'b0, 32'h999, 1'b0);
    tick(); tick(); idle(); #1;
    n_vec++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL jump_nt_taken got=%0h want=1", pred_taken); end
    n_vec++; if (pred_target !== 32'h10) begin n_err++; $display("FAIL jump_nt_target got=%08h want=00000010", pred_target); end
    n_vec++; if (branch_cnt !== 4'd10) begin n_err++; $display("FAIL jump_branch_cnt got=%0d want=10", branch_cnt); end
    n_vec++; if (mispred_cnt !== 4'd1) begin n_err++; $display("FAIL jump_mispred_cnt got=%0d want=1", mispred_cnt); end
  endtask

  task automatic test_flush();
    set_upd(1'b1, 32'h300, 1'b1, 1'b0, 32'h20, 1'b1);
    flush = 1'b1;
    tick(); idle(); lookup_pc = 32'h300; #1;
    n_vec++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL flush_hit_300 got=%0h want=0", pred_hit); end
    n_vec++; if (pred_target !== 32'h304) begin n_err++; $display("FAIL flush_target_300 got=%08h want=00000304", pred_target); end
    lookup_pc = 32'h200; #1;
    n_vec++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL flush_hit_200 got=%0h want=0", pred_hit); end
    n_vec++; if (branch_cnt !== 4'd11) begin n_err++; $display("FAIL flush_branch_cnt got=%0d want=11", branch_cnt); end
    n_vec++; if (mispred_cnt !== 4'd2) begin n_err++; $display("FAIL flush_mispred_cnt got=%0d want=2", mispred_cnt); end
    set_upd(1'b1, 32'h500, 1'b1, 1'b0, 32'h60, 1'b0);
    tick(); idle(); lookup_pc = 32'h500; #1;
    n_vec++; if (pred_target !== 32'h60) begin n_err++; $display("FAIL retrain_target got=%08h want=00000060", pred_target); end
    // asynchronous reset between edges
    rst = 1'b1; #1;
    n_vec++; if (branch_cnt !== 4'd0) begin n_err++; $display("FAIL areset_branch_cnt got=%0d want=0", branch_cnt); end
    n_vec++; if (mispred_cnt !== 4'd0) begin n_err++; $display("FAIL areset_mispred_cnt got=%0d want=0", mispred_cnt); end
    n_vec++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL areset_hit got=%0h want=0", pred_hit); end
    n_vec++; if (pred_target !== 32'h504) begin n_err++; $display("FAIL areset_target got=%08h want=00000504", pred_target); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    lookup_pc = 32'hFFFF_FFFC; #1;
    n_vec++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL wrap_hit got=%0h want=0", pred_hit); end
    n_vec++; if (pred_target !== 32'h0) begin n_err++; $display("FAIL wrap_target got=%08h want=00000000", pred_target); end
    set_upd(1'b0, 32'h400, 1'b1, 1'b1, 32'h70, 1'b1);
    tick(); idle(); lookup_pc = 32'h400; #1;
    n_vec++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL novalid_hit got=%0h want=0", pred_hit); end
    n_vec++; if (branch_cnt !== 4'd0) begin n_err++; $display("FAIL novalid_branch_cnt got=%0d want=0", branch_cnt); end
    for (int i = 0; i < 15; i++) begin
      set_upd(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 1'b0, 32'h0, 1'b1);
      tick();
    end
    idle(); lookup_pc = 32'h1000; #1;
    n_vec++; if (pred_hit !== 1'b0) begin n_err++; $display("FAIL nt_miss_hit got=%0h want=0", pred_hit); end
    n_vec++; if (branch_cnt !== 4'd15) begin n_err++; $display("FAIL b2b15_branch_cnt got=%0d want=15", branch_cnt); end
    n_vec++; if (mispred_cnt !== 4'd15) begin n_err++; $display("FAIL b2b15_mispred_cnt got=%0d want=15", mispred_cnt); end
    set_upd(1'b1, 32'h2000, 1'b0, 1'b0, 32'h0, 1'b1);
    tick(); idle(); #1;
    n_vec++; if (branch_cnt !== 4'd0) begin n_err++; $display("FAIL b2b16_branch_cnt got=%0d want=0", branch_cnt); end
    n_vec++; if (mispred_cnt !== 4'd0) begin n_err++; $display("FAIL b2b16_mispred_cnt got=%0d want=0", mispred_cnt); end
  endtask

  initial begin
    test_reset();
    test_train();
    test_alias();
    test_jump();
    test_flush();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
